pipeline_exec_ctrl: RTL and testbench

Execution sequencer for the MIPS `PIPELINE`. It sits between the debug unit and the pipeline and owns the pipeline clock-enable and the pipeline reset. It sequences program load, continuous run, single-step and post-HALT drain. It also counts executed cycles for readback over UART.

---
 rtl/pipeline_exec_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_exec_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer for the MIPS pipeline: owns clock-enable and reset of the pipeline.
// Optional breakpoint compare is built when EXEC_CTRL_BP_EN is defined.
module pipeline_exec_ctrl #(
    parameter int NB_PC        = 32,
    parameter int NB_CYC       = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_load_active,
    input  logic              i_cmd_run,
    input  logic              i_cmd_step,
    input  logic              i_cmd_stop,
    input  logic              i_halt,
    input  logic [NB_PC-1:0]  i_pc,
    input  logic [NB_PC-1:0]  i_bp_addr,
    input  logic              i_bp_valid,
    output logic              o_clk_en,
    output logic              o_pipe_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_bp_hit,
    output logic [2:0]        o_state,
    output logic [NB_CYC-1:0] o_cycle_count
);

    localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [NB_DRAIN-1:0] drain_cnt_q, drain_cnt_d;
    logic                halt_seen_q, halt_seen_d;
    logic                bp_hit_q, bp_hit_d;
    logic                done_q, done_d;
    logic [NB_CYC-1:0]   cycle_count_q, cycle_count_d;
    logic                clk_en;
    logic                bp_match;

`ifdef EXEC_CTRL_BP_EN
    assign bp_match = i_bp_valid && (i_pc == i_bp_addr);
`else
    logic unused_bp;
    assign bp_match  = 1'b0;
    assign unused_bp = ^{i_bp_valid, i_bp_addr, i_pc};
`endif

    assign clk_en = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        halt_seen_d   = halt_seen_q;
        bp_hit_d      = bp_hit_q;
        cycle_count_d = cycle_count_q;

        if (clk_en && (cycle_count_q != {NB_CYC{1'b1}})) begin
            cycle_count_d = cycle_count_q + NB_CYC'(1);
        end

        if (i_load_active) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_cmd_run) begin
                        state_d  = ST_RUN;
                        bp_hit_d = 1'b0;
                    end else if (i_cmd_step) begin
                        state_d  = ST_STEP;
                        bp_hit_d = 1'b0;
                    end
                end
                ST_LOAD: state_d = ST_IDLE;
                ST_RUN: begin
                    // A HALT already caught while stepping: this cycle counts toward the drain.
                    if (halt_seen_q) begin
                        drain_cnt_d = drain_cnt_q - NB_DRAIN'(1);
                        state_d     = (drain_cnt_q <= NB_DRAIN'(1)) ? ST_DONE : ST_DRAIN;
                    end else if (i_halt) begin
                        drain_cnt_d = NB_DRAIN'(DRAIN_CYCLES);
                        state_d     = ST_DRAIN;
                    end else if (bp_match) begin
                        bp_hit_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (i_cmd_stop) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STEP: begin
                    state_d = ST_IDLE;
                    if (halt_seen_q) begin
                        drain_cnt_d = drain_cnt_q - NB_DRAIN'(1);
                        if (drain_cnt_q <= NB_DRAIN'(1)) begin
                            state_d = ST_DONE;
                        end
                    end else if (i_halt) begin
                        halt_seen_d = 1'b1;
                        drain_cnt_d = NB_DRAIN'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_d = drain_cnt_q - NB_DRAIN'(1);
                    if (drain_cnt_q <= NB_DRAIN'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_q == ST_LOAD) begin
            cycle_count_d = '0;
            halt_seen_d   = 1'b0;
            drain_cnt_d   = '0;
            bp_hit_d      = 1'b0;
        end

        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            drain_cnt_q   <= '0;
            halt_seen_q   <= 1'b0;
            bp_hit_q      <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            halt_seen_q   <= halt_seen_d;
            bp_hit_q      <= bp_hit_d;
            done_q        <= done_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign o_clk_en      = clk_en;
    assign o_busy        = clk_en;
    assign o_pipe_reset  = (state_q == ST_LOAD);
    assign o_done        = done_q;
    assign o_bp_hit      = bp_hit_q;
    assign o_state       = state_q;
    assign o_cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl: vector table plus multi-cycle sequences.
// A 5-bit cycle counter is used so saturation is reachable.
module tb_pipeline_exec_ctrl;

    localparam int NB_PC  = 32;
    localparam int NB_CYC = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_active = 1'b0;
    logic              cmd_run = 1'b0;
    logic              cmd_step = 1'b0;
    logic              cmd_stop = 1'b0;
    logic              halt = 1'b0;
    logic [NB_PC-1:0]  pc = '0;
    logic [NB_PC-1:0]  bp_addr = '0;
    logic              bp_valid = 1'b0;
    logic              clk_en, pipe_reset, busy, done, bp_hit;
    logic [2:0]        state;
    logic [NB_CYC-1:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_exec_ctrl #(.NB_PC(NB_PC), .NB_CYC(NB_CYC), .DRAIN_CYCLES(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_load_active(load_active),
        .i_cmd_run(cmd_run), .i_cmd_step(cmd_step), .i_cmd_stop(cmd_stop),
        .i_halt(halt), .i_pc(pc), .i_bp_addr(bp_addr), .i_bp_valid(bp_valid),
        .o_clk_en(clk_en), .o_pipe_reset(pipe_reset), .o_busy(busy), .o_done(done),
        .o_bp_hit(bp_hit), .o_state(state), .o_cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       load, run, step, stop, hlt;
        logic [2:0] st;
        logic       en, prst, bsy, dn;
        logic [4:0] cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input int n);
        @(negedge clk) load_active = 1'b1;
        repeat (n) @(negedge clk);
        load_active = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_run();
        @(negedge clk) cmd_run = 1'b1;
        @(negedge clk) cmd_run = 1'b0;
    endtask

    int n_en, n_done;

    initial begin
        // load run step stop halt | state en prst busy done count
        vecs[0]  = '{0,0,0,1,0, 3'd0,0,0,0,0, 5'd0};
        vecs[1]  = '{0,1,1,0,0, 3'd2,1,0,1,0, 5'd0};
        vecs[2]  = '{0,0,0,0,0, 3'd2,1,0,1,0, 5'd1};
        vecs[3]  = '{0,0,0,1,0, 3'd0,0,0,0,0, 5'd2};
        vecs[4]  = '{0,0,0,0,0, 3'd0,0,0,0,0, 5'd2};
        vecs[5]  = '{0,0,1,0,0, 3'd3,1,0,1,0, 5'd2};
        vecs[6]  = '{0,0,0,0,0, 3'd0,0,0,0,0, 5'd3};
        vecs[7]  = '{0,1,0,1,0, 3'd2,1,0,1,0, 5'd3};
        vecs[8]  = '{0,0,0,1,1, 3'd4,1,0,1,0, 5'd4};
        vecs[9]  = '{0,1,0,0,0, 3'd4,1,0,1,0, 5'd5};
        vecs[10] = '{0,0,1,0,0, 3'd4,1,0,1,0, 5'd6};
        vecs[11] = '{0,0,0,1,0, 3'd4,1,0,1,0, 5'd7};
        vecs[12] = '{0,0,0,0,0, 3'd5,0,0,0,1, 5'd8};
        vecs[13] = '{0,1,0,0,0, 3'd5,0,0,0,0, 5'd8};
        vecs[14] = '{1,0,0,0,0, 3'd1,0,1,0,0, 5'd8};
        vecs[15] = '{1,0,0,0,0, 3'd1,0,1,0,0, 5'd0};
        vecs[16] = '{0,0,0,0,0, 3'd0,0,0,0,0, 5'd0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_outs", {27'd0, clk_en, pipe_reset, busy, done, bp_hit}, 32'd0);
        check("reset_count", 32'(cycle_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            load_active = vecs[i].load;
            cmd_run     = vecs[i].run;
            cmd_step    = vecs[i].step;
            cmd_stop    = vecs[i].stop;
            halt        = vecs[i].hlt;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d_outs", i), {28'd0, clk_en, pipe_reset, busy, done},
                  {28'd0, vecs[i].en, vecs[i].prst, vecs[i].bsy, vecs[i].dn});
            check($sformatf("vec%0d_count", i), 32'(cycle_count), 32'(vecs[i].cnt));
        end
        @(negedge clk);
        {load_active, cmd_run, cmd_step, cmd_stop, halt} = '0;

        // Load held for 10 cycles while running
        pulse_run();
        repeat (3) @(negedge clk);
        load_active = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("load%0d_prst_en", i), {30'd0, pipe_reset, clk_en}, 32'b10);
            if (i == 9) load_active = 1'b0;
        end
        @(negedge clk);
        check("load_exit_state", 32'(state), 32'd0);
        check("load_count", 32'(cycle_count), 32'd0);

        // Run to HALT after 20 enabled cycles
        pulse_run();
        n_en = 0;
        for (int i = 0; i < 20; i++) begin
            if (clk_en) n_en++;
            if (i == 19) halt = 1'b1;
            @(negedge clk);
        end
        halt = 1'b0;
        check("run_enabled", 32'(n_en), 32'd20);
        n_en = 0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (clk_en) n_en++;
            if (done) n_done++;
            @(negedge clk);
        end
        check("drain_enabled", 32'(n_en), 32'd4);
        check("done_pulses", 32'(n_done), 32'd1);
        check("run_halt_state", 32'(state), 32'd5);
        check("run_halt_count", 32'(cycle_count), 32'd24);

        // Step to HALT: halt seen on 3rd step, DONE after 7th
        do_load(2);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk) cmd_step = 1'b1;
            @(negedge clk) cmd_step = 1'b0;
            halt = (i == 2);
            check($sformatf("step%0d_en", i), 32'(clk_en), 32'd1);
            @(negedge clk) halt = 1'b0;
            check($sformatf("step%0d_after", i), {27'd0, clk_en, done, state},
                  (i == 6) ? {27'd0, 1'b0, 1'b1, 3'd5} : 32'd0);
        end
        @(negedge clk) cmd_step = 1'b1;
        @(negedge clk) cmd_step = 1'b0;
        check("step8_no_en", 32'(clk_en), 32'd0);
        check("step8_state", 32'(state), 32'd5);
        check("step_count", 32'(cycle_count), 32'd7);

        // Counter saturation
        do_load(2);
        pulse_run();
        repeat (40) @(negedge clk);
        cmd_stop = 1'b1;
        @(negedge clk) cmd_stop = 1'b0;
        check("sat_state", 32'(state), 32'd0);
        check("sat_count", 32'(cycle_count), 32'd31);

        // Breakpoint at PC+4 = 0x10
        do_load(2);
        bp_addr  = 32'h10;
        bp_valid = 1'b1;
        pc       = '0;
        pulse_run();
        pc = 32'h4;
        @(negedge clk) pc = 32'h8;
        @(negedge clk) pc = 32'hC;
        @(negedge clk) pc = 32'h10;
        @(posedge clk);
        #1;
`ifdef EXEC_CTRL_BP_EN
        check("bp_state", 32'(state), 32'd0);
        check("bp_hit", 32'(bp_hit), 32'd1);
        @(negedge clk);
        pc = '0;
        cmd_step = 1'b1;
        @(negedge clk) cmd_step = 1'b0;
        check("bp_clear", 32'(bp_hit), 32'd0);
        check("bp_step_state", 32'(state), 32'd3);
`else
        check("bp_off_state", 32'(state), 32'd2);
        check("bp_off_hit", 32'(bp_hit), 32'd0);
        @(negedge clk);
        pc = '0;
        cmd_stop = 1'b1;
        @(negedge clk) cmd_stop = 1'b0;
        check("bp_off_stop", 32'(state), 32'd0);
`endif
        bp_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of RUN
        pulse_run();
        repeat (5) @(negedge clk);
        check("pre_reset_run", 32'(state), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_outs", {27'd0, clk_en, pipe_reset, busy, done, bp_hit}, 32'd0);
        check("async_count", 32'(cycle_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
